enigma_rotor_sequencer: RTL and testbench
=========================================

# enigma_rotor_sequencer

Per-keypress controller for the Enigma cipher datapath (letter encoder, three-rotor stack, reflector, return path, letter decoder). On each accepted key press it advances the three rotor positions with authentic notch stepping, then presents the plaintext letter to the datapath. It waits a fixed datapath latency, captures the cipher letter and holds off until the key is released. It sits between the switch/key front end and the combinational rotor/reflector chain, and is the only owner of rotor position state.

## Interface
Parameters:
- `NOTCH_R`, 21: right-rotor turnover position (0–25); middle rotor steps when the right rotor leaves this position.
- `NOTCH_M`, 4: middle-rotor turnover position (0–25).
- `DP_LATENCY`, 2: datapath settle cycles between position update and capture; legal range 1–15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  level; high while the key is pressed.
- `letter_in`  in  5  plaintext letter index, 0 = A … 25 = Z.
- `cfg_load`  in  1  loads start positions; honoured only in IDLE.
- `cfg_pos`  in  15  start positions {left[14:10], mid[9:5], right[4:0]}.
- `pos_l`, `pos_m`, `pos_r`  out  5 each  current rotor positions driven to the rotor stack.
- `dp_letter`  out  5  letter driven into the datapath.
- `dp_result`  in  5  cipher letter index returned by the datapath.
- `cipher_out`  out  5  captured cipher letter.
- `cipher_valid`  out  1  one-cycle pulse when `cipher_out` updates.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse when a press is rejected.

## Operation
- States: IDLE, STEP, WAIT, CAPTURE, RELEASE.
- IDLE with `key_valid`=1 and `letter_in`≤25:
  - latch `letter_in` into `dp_letter`;
  - go to STEP.
- IDLE with `key_valid`=1 and `letter_in`>25:
  - pulse `err`;
  - go to RELEASE with no stepping and no capture.
- IDLE with `cfg_load`=1 and `key_valid`=0: load `cfg_pos`. A `cfg_pos` field >25 is loaded modulo 26.
- IDLE with `cfg_load` and `key_valid` both high: the key press wins and `cfg_load` is ignored.
- `cfg_load` outside IDLE is ignored.
- STEP updates all three positions in a single edge:
  - right: always +1.
  - middle: +1 if `pos_r`==`NOTCH_R`, or (double-step, see Configuration) `pos_m`==`NOTCH_M`.
  - left: +1 if `pos_m`==`NOTCH_M`.
  - Every position wraps 25→0. Notch tests use pre-step values.
- WAIT counts `DP_LATENCY` cycles with `dp_letter` and the positions held stable.
- CAPTURE:
  - register `dp_result` into `cipher_out`;
  - pulse `cipher_valid`;
  - go to RELEASE.
- RELEASE holds until `key_valid`=0, then returns to IDLE. A held key therefore produces exactly one encryption.
- `dp_letter` and `cipher_out` hold their last values when idle.

## Timing
- Reset values:
  - positions, `dp_letter` and `cipher_out`: 0;
  - `cipher_valid`, `busy` and `err`: 0;
  - state IDLE, WAIT counter 0.
- `resetn` low on any edge aborts an operation in flight:
  - all of the above return to reset values on that edge;
  - no `cipher_valid` is issued for the aborted press.
- Press cycle, with E0 the edge that accepts the press:
  - E0: `busy` rises and `dp_letter` is latched.
  - E1: positions update.
  - E1+`DP_LATENCY`: capture; `cipher_valid` is high for the following cycle.
  - Total: `DP_LATENCY`+1 edges from E0 to capture.
- The earliest next acceptance is one edge after `key_valid` is seen low in RELEASE.
- Rejected press: `err` is high for the cycle after E0, and `busy` stays high until release.

## Configuration
- `ENIGMA_DOUBLE_STEP_EN` defined: the middle rotor also steps when `pos_m`==`NOTCH_M`. This is the historical double-step, where the middle rotor advances on two consecutive presses.
- `ENIGMA_DOUBLE_STEP_EN` undefined: pure odometer. The middle rotor steps only when `pos_r`==`NOTCH_R`. Left-rotor stepping is unchanged.

## Test plan
- Reset and first press:
  - reset, then press `letter_in`=0 at positions (0,0,0) -> positions become (0,0,1);
  - `dp_letter`=0;
  - `cipher_valid` pulses 3 edges after acceptance with `cipher_out`=`dp_result`;
  - `busy` stays high until `key_valid` drops.
- Right turnover and wrap:
  - `cfg_pos`=(0,0,21), press -> (0,1,22);
  - `cfg_pos`=(0,25,25) with right not at notch, press -> (0,25,0).
- Double step, `cfg_pos`=(0,3,21), two presses:
  - with `ENIGMA_DOUBLE_STEP_EN`: (0,4,22) then (1,5,23);
  - without: (0,4,22) then (1,4,23).
- Held key and invalid input:
  - hold `key_valid` high for 20 cycles -> exactly one step and one `cipher_valid`;
  - `letter_in`=27 -> `err` pulse, positions unchanged, no `cipher_valid`.
- Config gating:
  - `cfg_load` asserted during WAIT -> positions unaffected;
  - `cfg_load` and `key_valid` asserted together in IDLE -> press processed, config ignored.
- Reset mid-operation: drive `resetn` low during WAIT -> all outputs 0 next edge and no `cipher_valid` afterwards.

Source files
------------

// File: rtl/enigma_rotor_sequencer_if.sv
// Signal bundle between the key/config front end, the rotor datapath and the sequencer.
// The sequencer takes the slave view; the front end or bench takes the master view.
interface enigma_rotor_sequencer_if;
  logic        key_valid;
  logic [4:0]  letter_in;
  logic        cfg_load;
  logic [14:0] cfg_pos;
  logic [4:0]  pos_l;
  logic [4:0]  pos_m;
  logic [4:0]  pos_r;
  logic [4:0]  dp_letter;
  logic [4:0]  dp_result;
  logic [4:0]  cipher_out;
  logic        cipher_valid;
  logic        busy;
  logic        err;

  modport slave (
    input  key_valid, letter_in, cfg_load, cfg_pos, dp_result,
    output pos_l, pos_m, pos_r, dp_letter, cipher_out, cipher_valid, busy, err
  );

  modport master (
    output key_valid, letter_in, cfg_load, cfg_pos, dp_result,
    input  pos_l, pos_m, pos_r, dp_letter, cipher_out, cipher_valid, busy, err
  );
endinterface

// File: rtl/enigma_rotor_sequencer.sv
// Per-keypress Enigma controller: steps rotors, drives the datapath, captures the cipher letter.
// Define ENIGMA_DOUBLE_STEP_EN for the historical middle-rotor double step; default is pure odometer.
//
// state     | meaning
// S_IDLE    | waiting for a key press or a config load
// S_STEP    | advancing rotor positions (one edge)
// S_WAIT    | datapath settling, DP_LATENCY cycles
// S_CAPTURE | cipher_out just updated, cipher_valid high
// S_RELEASE | waiting for the key to be released
module enigma_rotor_sequencer #(
  parameter int NOTCH_R    = 21,
  parameter int NOTCH_M    = 4,
  parameter int DP_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  enigma_rotor_sequencer_if.slave  bus
);

  localparam logic [4:0] NOTCH_R5  = 5'(NOTCH_R);
  localparam logic [4:0] NOTCH_M5  = 5'(NOTCH_M);
  localparam logic [3:0] WAIT_LOAD = 4'(DP_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] pos_l_q, pos_l_nxt;
  logic [4:0] pos_m_q, pos_m_nxt;
  logic [4:0] pos_r_q, pos_r_nxt;
  logic [4:0] dp_letter_q, dp_letter_nxt;
  logic [4:0] cipher_q, cipher_nxt;
  logic       cv_q, cv_nxt;
  logic       err_q, err_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic       step_m;
  logic       step_l;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] mod26(input logic [4:0] v);
    return (v > 5'd25) ? v - 5'd26 : v;
  endfunction

  // Notch tests look at pre-step positions.
`ifdef ENIGMA_DOUBLE_STEP_EN
  assign step_m = (pos_r_q == NOTCH_R5) || (pos_m_q == NOTCH_M5);
`else
  assign step_m = (pos_r_q == NOTCH_R5);
`endif
  assign step_l = (pos_m_q == NOTCH_M5);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      pos_l_q     <= '0;
      pos_m_q     <= '0;
      pos_r_q     <= '0;
      dp_letter_q <= '0;
      cipher_q    <= '0;
      cv_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state       <= state_nxt;
      pos_l_q     <= pos_l_nxt;
      pos_m_q     <= pos_m_nxt;
      pos_r_q     <= pos_r_nxt;
      dp_letter_q <= dp_letter_nxt;
      cipher_q    <= cipher_nxt;
      cv_q        <= cv_nxt;
      err_q       <= err_nxt;
      cnt_q       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pos_l_nxt     = pos_l_q;
    pos_m_nxt     = pos_m_q;
    pos_r_nxt     = pos_r_q;
    dp_letter_nxt = dp_letter_q;
    cipher_nxt    = cipher_q;
    cv_nxt        = 1'b0;
    err_nxt       = 1'b0;
    cnt_nxt       = cnt_q;
    case (state)
      S_IDLE: begin
        if (bus.key_valid) begin
          if (bus.letter_in <= 5'd25) begin
            dp_letter_nxt = bus.letter_in;
            state_nxt     = S_STEP;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_RELEASE;
          end
        end else if (bus.cfg_load) begin
          pos_l_nxt = mod26(bus.cfg_pos[14:10]);
          pos_m_nxt = mod26(bus.cfg_pos[9:5]);
          pos_r_nxt = mod26(bus.cfg_pos[4:0]);
        end
      end
      S_STEP: begin
        pos_r_nxt = inc26(pos_r_q);
        pos_m_nxt = step_m ? inc26(pos_m_q) : pos_m_q;
        pos_l_nxt = step_l ? inc26(pos_l_q) : pos_l_q;
        cnt_nxt   = WAIT_LOAD;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Capture happens on the edge that ends the last settle cycle.
        if (cnt_q == 4'd0) begin
          cipher_nxt = bus.dp_result;
          cv_nxt     = 1'b1;
          state_nxt  = S_CAPTURE;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (!bus.key_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.pos_l        = pos_l_q;
  assign bus.pos_m        = pos_m_q;
  assign bus.pos_r        = pos_r_q;
  assign bus.dp_letter    = dp_letter_q;
  assign bus.cipher_out   = cipher_q;
  assign bus.cipher_valid = cv_q;
  assign bus.err          = err_q;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_enigma_rotor_sequencer.sv
// Directed plus randomized bench for enigma_rotor_sequencer against an arithmetic rotor model.
// Datapath stand-in: cipher = (letter + r + 3*m + 7*l) mod 26.
module tb_enigma_rotor_sequencer;
  localparam int NOTCH_R = 21;
  localparam int NOTCH_M = 4;
  localparam int LAT     = 2;
`ifdef ENIGMA_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   ml = 0, mm = 0, mr = 0;
  int   dp_res_i;

  enigma_rotor_sequencer_if bus ();

  enigma_rotor_sequencer #(.NOTCH_R(NOTCH_R), .NOTCH_M(NOTCH_M), .DP_LATENCY(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    dp_res_i = (int'(bus.dp_letter) + int'(bus.pos_r) + 3 * int'(bus.pos_m) + 7 * int'(bus.pos_l)) % 26;
    bus.dp_result = 5'(dp_res_i);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag);
    check({tag, ".pos_l"}, int'(bus.pos_l), ml);
    check({tag, ".pos_m"}, int'(bus.pos_m), mm);
    check({tag, ".pos_r"}, int'(bus.pos_r), mr);
  endtask

  task automatic model_step();
    bit sm, sl;
    sm = (mr == NOTCH_R) || (DS && mm == NOTCH_M);
    sl = (mm == NOTCH_M);
    mr = (mr + 1) % 26;
    if (sm) mm = (mm + 1) % 26;
    if (sl) ml = (ml + 1) % 26;
  endtask

  task automatic load_cfg(input int l, input int m, input int r);
    @(negedge clk);
    bus.cfg_load = 1'b1;
    bus.cfg_pos  = {5'(l), 5'(m), 5'(r)};
    @(negedge clk);
    bus.cfg_load = 1'b0;
    ml = l % 26;
    mm = m % 26;
    mr = r % 26;
    check_pos("cfg");
  endtask

  // cfg_mode: 0 none, 1 cfg_load together with the key, 2 cfg_load during WAIT
  task automatic press(input int letter, input int hold, input int cfg_mode);
    bit valid;
    int n_cv, first_cv, exp_cipher;
    valid    = (letter <= 25);
    n_cv     = 0;
    first_cv = -1;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.letter_in = 5'(letter);
    if (cfg_mode == 1) begin
      bus.cfg_load = 1'b1;
      bus.cfg_pos  = 15'($urandom);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.cfg_load = 1'b0;
        check("busy_after_accept", int'(bus.busy), 1);
        check("err_after_accept", int'(bus.err), valid ? 0 : 1);
        check_pos("pre_step");
        if (valid) begin
          check("dp_letter", int'(bus.dp_letter), letter);
          model_step();
          exp_cipher = (letter + mr + 3 * mm + 7 * ml) % 26;
        end
      end
      if (i == 1) begin
        check("err_second_cycle", int'(bus.err), 0);
        check_pos(valid ? "post_step" : "reject_hold");
        if (cfg_mode == 2) begin
          bus.cfg_load = 1'b1;
          bus.cfg_pos  = 15'($urandom);
        end
      end
      if (i == 2) bus.cfg_load = 1'b0;
      if (bus.cipher_valid) begin
        n_cv++;
        if (first_cv < 0) first_cv = i;
        check("cipher_out", int'(bus.cipher_out), exp_cipher);
      end
    end
    check("busy_held", int'(bus.busy), 1);
    check_pos("held_end");
    bus.key_valid = 1'b0;
    @(negedge clk);
    check("busy_released", int'(bus.busy), 0);
    check("cipher_valid_count", n_cv, valid ? 1 : 0);
    if (valid) check("cipher_valid_edge", first_cv, LAT + 1);
  endtask

  initial begin
    int cv_seen;
    bus.key_valid = 1'b0;
    bus.letter_in = '0;
    bus.cfg_load  = 1'b0;
    bus.cfg_pos   = '0;
    repeat (3) @(negedge clk);
    check_pos("reset");
    check("reset.dp_letter", int'(bus.dp_letter), 0);
    check("reset.cipher_out", int'(bus.cipher_out), 0);
    check("reset.cipher_valid", int'(bus.cipher_valid), 0);
    check("reset.busy", int'(bus.busy), 0);
    check("reset.err", int'(bus.err), 0);
    resetn = 1'b1;

    press(0, 6, 0);
    check("first_press.pos_r", int'(bus.pos_r), 1);

    load_cfg(0, 0, 21);
    press(5, 6, 0);
    check("right_turnover.pos_m", int'(bus.pos_m), 1);

    load_cfg(0, 25, 25);
    press(11, 6, 0);
    check("wrap.pos_r", int'(bus.pos_r), 0);
    check("wrap.pos_m", int'(bus.pos_m), 25);

    load_cfg(0, 3, 21);
    press(7, 6, 0);
    check("dstep1.pos_m", int'(bus.pos_m), 4);
    press(19, 6, 0);
    check("dstep2.pos_m", int'(bus.pos_m), DS ? 5 : 4);
    check("dstep2.pos_l", int'(bus.pos_l), 1);

    press(3, 20, 0);
    press(27, 6, 0);
    press(31, 7, 0);
    press(9, 8, 2);
    press(14, 6, 1);
    load_cfg(31, 26, 29);
    press(25, 6, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0)
        load_cfg(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      press(int'($urandom_range(0, 27)), int'($urandom_range(6, 10)), int'($urandom_range(0, 2)));
    end

    load_cfg(2, 3, 4);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.letter_in = 5'd12;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    bus.key_valid = 1'b0;
    @(negedge clk);
    ml = 0;
    mm = 0;
    mr = 0;
    check_pos("abort");
    check("abort.dp_letter", int'(bus.dp_letter), 0);
    check("abort.cipher_out", int'(bus.cipher_out), 0);
    check("abort.cipher_valid", int'(bus.cipher_valid), 0);
    check("abort.busy", int'(bus.busy), 0);
    check("abort.err", int'(bus.err), 0);
    resetn = 1'b1;
    cv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.cipher_valid) cv_seen++;
    end
    check("abort.no_cipher_valid", cv_seen, 0);
    press(20, 6, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
